bitwise_resp_checker: RTL and testbench

//  Consumer end of the bitwise operand/result stream. Accepts {x,y,z} triples from the bitwise

---
 rtl/bitwise_pkg.sv | 22 ++
 rtl/bitwise_ref_model.sv | 15 +
 rtl/bitwise_resp_checker.sv | 147 ++++++++++++++
 tb/tb_bitwise_resp_checker.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_pkg.sv
// Shared definitions for the bitwise datapath and its response checker.
package bitwise_pkg;

  localparam int unsigned BW_MAX_W = 32;

  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_NAND} bw_op_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} chk_state_t;

  // Evaluated at full width; callers truncate to their operand width.
  function automatic logic [BW_MAX_W-1:0] bw_eval(input bw_op_t op,
                                                  input logic [BW_MAX_W-1:0] a,
                                                  input logic [BW_MAX_W-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NAND: return ~(a & b);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/bitwise_ref_model.sv
// Combinational reference: expected result of the latched op applied to x and y.
module bitwise_ref_model
  import bitwise_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [1:0]   i_op,
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  output logic [W-1:0] o_exp
);

  assign o_exp = W'(bw_eval(bw_op_t'(i_op), BW_MAX_W'(i_x), BW_MAX_W'(i_y)));

endmodule

// File: rtl/bitwise_resp_checker.sv
// Response checker: counts matching/mismatching {x,y,z} triples over a run of n_vec vectors.
// Optional first-fail capture outputs when BWCHK_FIRST_FAIL_EN is defined.
module bitwise_resp_checker
  import bitwise_pkg::*;
#(
  parameter int W     = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] n_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic [W-1:0]     z,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             busy,
  output logic             done,
  output logic             pass
`ifdef BWCHK_FIRST_FAIL_EN
  ,
  output logic             ff_valid,
  output logic [W-1:0]     ff_x,
  output logic [W-1:0]     ff_y,
  output logic [W-1:0]     ff_z,
  output logic [CNT_W-1:0] ff_idx
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_t       r_state;
  bw_op_t           r_op;
  logic [CNT_W-1:0] r_nvec;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;

  logic [W-1:0]     w_exp;
  logic             w_start_go;
  logic             w_count;
  logic             w_match;
  logic             w_last;

  bitwise_ref_model #(.W(W)) u_ref (
    .i_op  (r_op),
    .i_x   (x),
    .i_y   (y),
    .o_exp (w_exp)
  );

  // abort has priority over both a new start and an in-flight transfer
  assign w_start_go = start && !abort && (r_state != RUN);
  assign w_count    = in_valid && (r_state == RUN) && !abort;
  assign w_match    = (w_exp == z);
  assign w_last     = ((CNT_W+1)'(r_acc) + 1'b1) == (CNT_W+1)'(r_nvec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op       <= OP_AND;
      r_nvec     <= '0;
      r_acc      <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else if (abort) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_go) begin
            r_op       <= bw_op_t'(op);
            r_nvec     <= n_vec;
            r_acc      <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_state    <= (n_vec == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (w_count) begin
            r_acc <= r_acc + 1'b1;
            if (w_match)
              r_pass_cnt <= (r_pass_cnt == CNT_MAX) ? r_pass_cnt : r_pass_cnt + 1'b1;
            else
              r_fail_cnt <= (r_fail_cnt == CNT_MAX) ? r_fail_cnt : r_fail_cnt + 1'b1;
            if (w_last)
              r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready = (r_state == RUN);
  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);
  assign pass     = (r_state == DONE) && (r_fail_cnt == '0);
  assign pass_cnt = r_pass_cnt;
  assign fail_cnt = r_fail_cnt;

`ifdef BWCHK_FIRST_FAIL_EN
  logic             r_ff_valid;
  logic [W-1:0]     r_ff_x;
  logic [W-1:0]     r_ff_y;
  logic [W-1:0]     r_ff_z;
  logic [CNT_W-1:0] r_ff_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ff_valid <= 1'b0;
      r_ff_x     <= '0;
      r_ff_y     <= '0;
      r_ff_z     <= '0;
      r_ff_idx   <= '0;
    end else if (abort || w_start_go) begin
      r_ff_valid <= 1'b0;
    end else if (w_count && !w_match && !r_ff_valid) begin
      r_ff_valid <= 1'b1;
      r_ff_x     <= x;
      r_ff_y     <= y;
      r_ff_z     <= z;
      r_ff_idx   <= r_acc;
    end
  end

  assign ff_valid = r_ff_valid;
  assign ff_x     = r_ff_x;
  assign ff_y     = r_ff_y;
  assign ff_z     = r_ff_z;
  assign ff_idx   = r_ff_idx;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && in_valid)
      assert (!$isunknown({x, y, z}));
  end
`endif

endmodule

// File: tb/tb_bitwise_resp_checker.sv
// Directed, table-driven bench for bitwise_resp_checker (BWCHK_FIRST_FAIL_EN optional).
module tb_bitwise_resp_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, in_valid;
  logic [1:0] op;
  logic [7:0] n_vec;
  logic [2:0] x, y, z;
  logic       in_ready, busy, done, pass;
  logic [7:0] pass_cnt, fail_cnt;

  logic       s_start, s_in_valid;
  logic [1:0] s_n_vec;
  logic       s_in_ready, s_busy, s_done, s_pass;
  logic [1:0] s_pass_cnt, s_fail_cnt;

`ifdef BWCHK_FIRST_FAIL_EN
  logic       ff_valid;
  logic [2:0] ff_x, ff_y, ff_z;
  logic [7:0] ff_idx;
  logic       s_ff_valid;
  logic [2:0] s_ff_x, s_ff_y, s_ff_z;
  logic [1:0] s_ff_idx;
`endif

  bitwise_resp_checker #(.W(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op(op), .n_vec(n_vec),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .z(z),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .busy(busy), .done(done), .pass(pass)
`ifdef BWCHK_FIRST_FAIL_EN
    , .ff_valid(ff_valid), .ff_x(ff_x), .ff_y(ff_y), .ff_z(ff_z), .ff_idx(ff_idx)
`endif
  );

  bitwise_resp_checker #(.W(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(s_start), .abort(abort), .op(op), .n_vec(s_n_vec),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .x(x), .y(y), .z(z),
    .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt), .busy(s_busy), .done(s_done), .pass(s_pass)
`ifdef BWCHK_FIRST_FAIL_EN
    , .ff_valid(s_ff_valid), .ff_x(s_ff_x), .ff_y(s_ff_y), .ff_z(s_ff_z), .ff_idx(s_ff_idx)
`endif
  );

  typedef struct {
    logic [1:0]       op;
    int unsigned      n;
    logic [2:0][2:0]  xs;
    logic [2:0][2:0]  ys;
    logic [2:0][2:0]  zs;
    int unsigned      e_pass;
    int unsigned      e_fail;
    logic             e_ok;
    logic             e_ffv;
    logic [2:0]       e_ffx, e_ffy, e_ffz;
    int unsigned      e_ffi;
  } vec_t;

  localparam int unsigned NV = 4;
  vec_t vecs [NV];

  int unsigned n_checks = 0;
  int unsigned n_passed = 0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int unsigned i, input logic [1:0] o, input int unsigned n,
                         input logic [2:0] x0, y0, z0, x1, y1, z1, x2, y2, z2,
                         input int unsigned ep, ef, input logic eok, effv,
                         input logic [2:0] ffx, ffy, ffz, input int unsigned ffi);
    vecs[i].op = o;  vecs[i].n = n;
    vecs[i].xs[0] = x0; vecs[i].ys[0] = y0; vecs[i].zs[0] = z0;
    vecs[i].xs[1] = x1; vecs[i].ys[1] = y1; vecs[i].zs[1] = z1;
    vecs[i].xs[2] = x2; vecs[i].ys[2] = y2; vecs[i].zs[2] = z2;
    vecs[i].e_pass = ep; vecs[i].e_fail = ef; vecs[i].e_ok = eok;
    vecs[i].e_ffv = effv; vecs[i].e_ffx = ffx; vecs[i].e_ffy = ffy; vecs[i].e_ffz = ffz;
    vecs[i].e_ffi = ffi;
  endtask

  task automatic xfer(input logic [2:0] xv, yv, zv);
    in_valid = 1'b1; x = xv; y = yv; z = zv;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // AND: 3&4=0, 7&5=5, 3&3=3 -> all pass
    set_vec(0, 2'b00, 3, 3,4,0, 7,5,5, 3,3,3, 3, 0, 1'b1, 1'b0, 0,0,0, 0);
    // XOR: 7^5=2 pass, 0^1=1 vs 0 fail at index 1
    set_vec(1, 2'b10, 2, 7,5,2, 0,1,0, 0,0,0, 1, 1, 1'b0, 1'b1, 0,1,0, 1);
    // OR: 1|2=3 pass, 4|4=4 pass, 0|0=0 vs 1 fail at index 2
    set_vec(2, 2'b01, 3, 1,2,3, 4,4,4, 0,0,1, 2, 1, 1'b0, 1'b1, 0,0,1, 2);
    // NAND (3 bits): ~(7&7)=0, ~(5&2)=7 -> all pass
    set_vec(3, 2'b11, 2, 7,7,0, 5,2,7, 0,0,0, 2, 0, 1'b1, 1'b0, 0,0,0, 0);

    rst = 1'b1; start = 0; abort = 0; op = 0; n_vec = 0; in_valid = 0;
    x = 0; y = 0; z = 0; s_start = 0; s_in_valid = 0; s_n_vec = 0;
    tick(); tick();
    chk("reset in_ready", in_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset pass", pass, 0);
    rst = 1'b0;
    tick();

    // Async reset mid-run after two accepted vectors
    op = 2'b00; n_vec = 3; start = 1; tick(); start = 0;
    xfer(3, 4, 0);
    xfer(7, 5, 5);
    chk("pre-reset pass_cnt", pass_cnt, 2);
    chk("pre-reset busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrun rst in_ready", in_ready, 0);
    chk("midrun rst busy", busy, 0);
    chk("midrun rst done", done, 0);
    chk("midrun rst pass", pass, 0);
    chk("midrun rst pass_cnt", pass_cnt, 0);
    chk("midrun rst fail_cnt", fail_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post-rst busy", busy, 0);
    chk("post-rst done", done, 0);
    chk("post-rst in_ready", in_ready, 0);

    // Table-driven runs
    for (int i = 0; i < NV; i++) begin
      op = vecs[i].op; n_vec = 8'(vecs[i].n); start = 1; tick(); start = 0;
      chk($sformatf("v%0d busy", i), busy, 1);
      for (int j = 0; j < int'(vecs[i].n); j++) begin
        chk($sformatf("v%0d in_ready[%0d]", i, j), in_ready, 1);
        xfer(vecs[i].xs[j], vecs[i].ys[j], vecs[i].zs[j]);
      end
      chk($sformatf("v%0d done", i), done, 1);
      chk($sformatf("v%0d in_ready after", i), in_ready, 0);
      chk($sformatf("v%0d pass_cnt", i), pass_cnt, vecs[i].e_pass);
      chk($sformatf("v%0d fail_cnt", i), fail_cnt, vecs[i].e_fail);
      chk($sformatf("v%0d pass", i), pass, vecs[i].e_ok);
`ifdef BWCHK_FIRST_FAIL_EN
      chk($sformatf("v%0d ff_valid", i), ff_valid, vecs[i].e_ffv);
      if (vecs[i].e_ffv) begin
        chk($sformatf("v%0d ff_x", i), ff_x, vecs[i].e_ffx);
        chk($sformatf("v%0d ff_y", i), ff_y, vecs[i].e_ffy);
        chk($sformatf("v%0d ff_z", i), ff_z, vecs[i].e_ffz);
        chk($sformatf("v%0d ff_idx", i), ff_idx, vecs[i].e_ffi);
      end
`endif
      tick();
      chk($sformatf("v%0d done held", i), done, 1);
    end

    // Handshake with a gap: valid 1-0-1, then extra pulses after DONE
    op = 2'b00; n_vec = 2; start = 1; tick(); start = 0;
    xfer(3, 1, 1);
    tick();
    xfer(2, 2, 2);
    chk("hs in_ready after 2nd", in_ready, 0);
    chk("hs done", done, 1);
    xfer(0, 0, 7);
    xfer(0, 0, 7);
    chk("hs pass_cnt", pass_cnt, 2);
    chk("hs fail_cnt", fail_cnt, 0);

    // n_vec=0 goes straight to DONE with a clean pass
    n_vec = 0; start = 1; tick(); start = 0;
    chk("n0 done", done, 1);
    chk("n0 pass", pass, 1);
    chk("n0 in_ready", in_ready, 0);
    chk("n0 pass_cnt cleared", pass_cnt, 0);
    tick();
    chk("n0 in_ready later", in_ready, 0);
    start = 1; abort = 1; n_vec = 2; tick(); start = 0; abort = 0;
    chk("start+abort done", done, 0);
    chk("start+abort busy", busy, 0);

    // start while in RUN is ignored; n_vec stays latched at 2
    op = 2'b01; n_vec = 2; start = 1; tick(); start = 0;
    xfer(1, 2, 3);
    n_vec = 5; start = 1; tick(); start = 0;
    chk("run-start busy", busy, 1);
    chk("run-start pass_cnt", pass_cnt, 1);
    xfer(0, 0, 0);
    chk("run-start done", done, 1);
    chk("run-start pass_cnt2", pass_cnt, 2);

    // abort mid-run after a failing vector
    op = 2'b00; n_vec = 3; start = 1; tick(); start = 0;
    xfer(1, 1, 0);
    chk("abort pre fail_cnt", fail_cnt, 1);
`ifdef BWCHK_FIRST_FAIL_EN
    chk("abort pre ff_valid", ff_valid, 1);
`endif
    abort = 1; tick(); abort = 0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort in_ready", in_ready, 0);
`ifdef BWCHK_FIRST_FAIL_EN
    chk("abort ff_valid", ff_valid, 0);
`endif

    // CNT_W=2 instance: all-fail run of 3, then re-start and repeat
    op = 2'b00; s_n_vec = 3;
    for (int r = 0; r < 2; r++) begin
      s_start = 1; tick(); s_start = 0;
      chk($sformatf("s%0d busy", r), s_busy, 1);
      chk($sformatf("s%0d fail_cnt cleared", r), s_fail_cnt, 0);
      for (int j = 0; j < 3; j++) begin
        s_in_valid = 1; x = 7; y = 7; z = 0;
        tick();
        s_in_valid = 0;
      end
      chk($sformatf("s%0d fail_cnt", r), s_fail_cnt, 3);
      chk($sformatf("s%0d pass_cnt", r), s_pass_cnt, 0);
      chk($sformatf("s%0d done", r), s_done, 1);
      chk($sformatf("s%0d pass", r), s_pass, 0);
      s_in_valid = 1; tick(); s_in_valid = 0;
      chk($sformatf("s%0d fail_cnt held", r), s_fail_cnt, 3);
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
